// File: rtl/alu_control_unit_if.sv
// ---------------------------------------------------------------------------
// alu_control_unit_if
//   Request/response handshake bundle between an operation source and the
//   ALU control unit.
//
//   start      : begin an operation (only honoured while the unit is idle)
//   op_in      : operation code 00 add, 01 sub, 10 mul, 11 div
//   in_valid   : operand byte present on the datapath input bus
//   in_ready   : control unit is in a load state and will take the byte
//   out_valid  : result byte on the datapath output bus is valid
//   out_ready  : consumer accepts the current result byte
//   busy       : control unit is anywhere but idle
//
//   master : the operation source / result consumer
//   slave  : the control unit
// ---------------------------------------------------------------------------
interface alu_control_unit_if;
    logic       start;
    logic [1:0] op_in;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output start,
        output op_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  start,
        input  op_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/alu_control_unit.sv
// ---------------------------------------------------------------------------
// alu_control_unit
//   Control FSM for the 8-bit arithmetic datapath. Runs add/sub, signed
//   radix-2 Booth multiply and unsigned restoring divide by sequencing the
//   datapath strobes, then hands the 16-bit result back as two bytes.
//
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : start/op_in, operand in_valid/in_ready, result
//                  out_valid/out_ready and busy (slave side)
//   cnt_done     : datapath counter is on its 8th shift
//   q0, qm1      : Booth pair Q[0], q[-1]
//   a7           : sign bit of accumulator A
//   op           : registered operation code to the datapath
//   c0           : load M from input bus
//   c1           : load Q from input bus
//   c2           : write adder result into A
//   c3           : adder subtracts (add/sub: result sign select as well)
//   c4, c5       : shift A:Q, step the counter
//   c6           : serial bit (shift-in / quotient bit)
//   c7, c8       : drive result high / low byte onto output bus
//   c9           : load A from input bus
//   c10          : write c6 into Q[0]
//   internal_rst : clear A, Q, q[-1], M and the counter
// ---------------------------------------------------------------------------
module alu_control_unit (
    input  logic                 clk,
    input  logic                 rst,
    alu_control_unit_if.slave    bus,
    input  logic                 cnt_done,
    input  logic                 q0,
    input  logic                 qm1,
    input  logic                 a7,
    output logic [1:0]           op,
    output logic                 c0,
    output logic                 c1,
    output logic                 c2,
    output logic                 c3,
    output logic                 c4,
    output logic                 c5,
    output logic                 c6,
    output logic                 c7,
    output logic                 c8,
    output logic                 c9,
    output logic                 c10,
    output logic                 internal_rst
);

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        LD_M,
        LD_Q,
        LD_A,
        MUL_OP,
        MUL_SH,
        DIV_SH,
        DIV_SUB,
        DIV_TEST,
        DIV_RST,
        OUT_HI,
        OUT_LO
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    logic   last_q, last_d;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            last_q  <= last_d;
        end
    end

    assign op = op_q;

    // -----------------------------------------------------------------------
    // Next state and Moore strobe decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        last_d        = last_q;

        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != IDLE);

        c0            = 1'b0;
        c1            = 1'b0;
        c2            = 1'b0;
        c3            = 1'b0;
        c4            = 1'b0;
        c5            = 1'b0;
        c6            = 1'b0;
        c7            = 1'b0;
        c8            = 1'b0;
        c9            = 1'b0;
        c10           = 1'b0;
        internal_rst  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op_in);
                    state_d = CLR;
                end
            end

            CLR: begin
                internal_rst = 1'b1;
                last_d       = 1'b0;
                state_d      = LD_M;
            end

            LD_M: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    c0      = 1'b1;
                    state_d = LD_Q;
                end
            end

            LD_Q: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    c1 = 1'b1;
                    unique case (op_q)
                        OP_ADD, OP_SUB: state_d = OUT_HI;
                        OP_MUL:         state_d = MUL_OP;
                        OP_DIV:         state_d = LD_A;
                        default:        state_d = OUT_HI;
                    endcase
                end
            end

            LD_A: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    c9      = 1'b1;
                    state_d = DIV_SH;
                end
            end

            // Booth pair 10 subtracts M, 01 adds M, 00/11 leave A alone.
            MUL_OP: begin
                c2      = q0 ^ qm1;
                c3      = q0 & ~qm1;
                state_d = MUL_SH;
            end

            // Arithmetic right shift: A's sign bit is fed back in.
            MUL_SH: begin
                c4      = 1'b1;
                c5      = 1'b1;
                c6      = a7;
                last_d  = cnt_done;
                state_d = cnt_done ? OUT_HI : MUL_OP;
            end

            DIV_SH: begin
                c4      = 1'b1;
                c5      = 1'b1;
                c6      = 1'b0;
                last_d  = cnt_done;
                state_d = DIV_SUB;
            end

            DIV_SUB: begin
                c2      = 1'b1;
                c3      = 1'b1;
                state_d = DIV_TEST;
            end

            // Quotient bit is 1 when A - M stayed non-negative.
            DIV_TEST: begin
                c10 = 1'b1;
                c6  = ~a7;
                if (a7) begin
                    state_d = DIV_RST;
                end else begin
                    state_d = last_q ? OUT_HI : DIV_SH;
                end
            end

            DIV_RST: begin
                c2      = 1'b1;
                c3      = 1'b0;
                state_d = last_q ? OUT_HI : DIV_SH;
            end

            // c3 keeps the add/sub adder in the right mode while the result
            // bytes are read out; mul/div read A and Q directly.
            OUT_HI: begin
                bus.out_valid = 1'b1;
                c7            = 1'b1;
                c3            = ~op_q[1] & op_q[0];
                if (bus.out_ready) begin
                    state_d = OUT_LO;
                end
            end

            OUT_LO: begin
                bus.out_valid = 1'b1;
                c8            = 1'b1;
                c3            = ~op_q[1] & op_q[0];
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_control_unit
//   Drives alu_control_unit together with a behavioural model of the 8-bit
//   datapath it controls, and compares the returned result bytes with plain
//   arithmetic (sum/difference, signed product, quotient/remainder).
// ---------------------------------------------------------------------------
module tb_alu_control_unit;

    logic       clk = 1'b0;
    logic       rst;

    alu_control_unit_if bus();

    logic       cnt_done, q0, qm1, a7;
    logic [1:0] op;
    logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10;
    logic       internal_rst;

    alu_control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cnt_done     (cnt_done),
        .q0           (q0),
        .qm1          (qm1),
        .a7           (a7),
        .op           (op),
        .c0           (c0),
        .c1           (c1),
        .c2           (c2),
        .c3           (c3),
        .c4           (c4),
        .c5           (c5),
        .c6           (c6),
        .c7           (c7),
        .c8           (c8),
        .c9           (c9),
        .c10          (c10),
        .internal_rst (internal_rst)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Datapath model: A, Q, q[-1], M, 4-bit shift counter
    // -----------------------------------------------------------------------
    logic [7:0] dp_a = '0, dp_q = '0, dp_m = '0;
    logic       dp_qm1 = 1'b0;
    logic [3:0] dp_cnt = '0;
    logic [7:0] in_byte;
    logic [8:0] addsub;
    logic [7:0] dp_out;

    always @(posedge clk) begin
        if (internal_rst) begin
            dp_a   <= '0;
            dp_q   <= '0;
            dp_m   <= '0;
            dp_qm1 <= 1'b0;
            dp_cnt <= '0;
        end else begin
            if (c0) dp_m <= in_byte;
            if (c1) dp_q <= in_byte;
            if (c9) dp_a <= in_byte;
            if (c2) dp_a <= c3 ? dp_a - dp_m : dp_a + dp_m;
            if (c4) begin
                if (op == 2'b10) begin
                    dp_a   <= {c6, dp_a[7:1]};
                    dp_q   <= {dp_a[0], dp_q[7:1]};
                    dp_qm1 <= dp_q[0];
                end else begin
                    dp_a <= {dp_a[6:0], dp_q[7]};
                    dp_q <= {dp_q[6:0], c6};
                end
            end
            if (c10) dp_q[0] <= c6;
            if (c5) dp_cnt <= dp_cnt + 4'd1;
        end
    end

    assign cnt_done = (dp_cnt == 4'd7);
    assign q0       = dp_q[0];
    assign qm1      = dp_qm1;
    assign a7       = dp_a[7];
    assign addsub   = c3 ? ({1'b0, dp_q} - {1'b0, dp_m}) : ({1'b0, dp_q} + {1'b0, dp_m});
    assign dp_out   = c7 ? (op[1] ? dp_a : {8{addsub[8]}}) :
                      c8 ? (op[1] ? dp_q : addsub[7:0]) : 8'h00;

    logic [16:0] all_outs;
    assign all_outs = {bus.in_ready, bus.out_valid, bus.busy, op, c0, c1, c2, c3, c4,
                       c5, c6, c7, c8, c9, c10, internal_rst};

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic logic [15:0] ref_result(input logic [1:0] opc, input logic [7:0] m,
                                               input logic [7:0] q, input logic [7:0] a);
        int s, dividend, quo, rem;
        case (opc)
            2'b00: begin
                s = int'(q) + int'(m);
                return {(s > 255) ? 8'hFF : 8'h00, s[7:0]};
            end
            2'b01: begin
                s = int'(q) - int'(m);
                return {(s < 0) ? 8'hFF : 8'h00, s[7:0]};
            end
            2'b10: begin
                s = int'($signed(q)) * int'($signed(m));
                return s[15:0];
            end
            default: begin
                dividend = int'(a) * 256 + int'(q);
                quo      = dividend / int'(m);
                rem      = dividend % int'(m);
                return {rem[7:0], quo[7:0]};
            end
        endcase
    endfunction

    // Runs one operation end to end. in_gap stalls in_valid before byte 2,
    // out_gap withholds out_ready while the high byte is offered.
    task automatic do_op(input logic [1:0] opc, input logic [7:0] m, input logic [7:0] q,
                         input logic [7:0] a, input int in_gap, input int out_gap,
                         output logic [7:0] hi, output logic [7:0] lo, output int lat,
                         output int xfers, output int shifts, output int viol, output bit tmo);
        logic [7:0] bytes [3];
        int  idx, cyc, gi, go;
        bit  done, seen, hi_seen, stalling;
        bytes[0] = m; bytes[1] = q; bytes[2] = a;
        idx = 0; cyc = 0; gi = in_gap; go = out_gap;
        done = 1'b0; seen = 1'b0; hi_seen = 1'b0;
        hi = '0; lo = '0; lat = 0; xfers = 0; shifts = 0; viol = 0; tmo = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_in = opc;
        while (!done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.start     = 1'b0;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            stalling      = 1'b0;
            if (c5) shifts++;
            if (bus.in_ready && idx < 3) begin
                if (idx == 1 && gi > 0) begin
                    gi--;
                end else begin
                    bus.in_valid = 1'b1;
                    in_byte      = bytes[idx];
                    idx++;
                    xfers++;
                end
            end
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                lat  = cyc;
            end
            if (bus.out_valid && c7) begin
                if (!hi_seen) begin
                    hi      = dp_out;
                    hi_seen = 1'b1;
                end else if (dp_out !== hi) begin
                    viol++;
                end
                if (go > 0) begin
                    go--;
                    stalling = 1'b1;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else if (bus.out_valid && c8) begin
                lo            = dp_out;
                bus.out_ready = 1'b1;
                done          = 1'b1;
            end
            #1;
            if (((c0 | c1 | c9) == 1'b1) !== (bus.in_ready && bus.in_valid)) viol++;
            if (stalling && ({c0, c1, c2, c4, c5, c8, c9, c10, internal_rst} != '0 || !c7))
                viol++;
        end
        if (!done) begin
            tmo = 1'b1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    // -----------------------------------------------------------------------
    // Directed and randomized sequence
    // -----------------------------------------------------------------------
    logic [7:0] hi, lo, rm, rq, ra;
    logic [1:0] ropc;
    int         lat, xf, sh, viol, cyc;
    bit         tmo;

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.op_in = 2'b00; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        in_byte = '0;
        #1;
        check("reset_outputs", 32'(all_outs), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_after_release", 32'(all_outs), 32'h0);

        // add 0x32 + 0x64
        do_op(2'b00, 8'h32, 8'h64, 8'h00, 0, 0, hi, lo, lat, xf, sh, viol, tmo);
        check("add_timeout", 32'(tmo), 32'h0);
        check("add_hi", 32'(hi), 32'h00);
        check("add_lo", 32'(lo), 32'h96);
        check("add_xfers", 32'(xf), 32'd2);
        check("add_latency", 32'(lat), 32'd4);
        check("add_strobes", 32'(viol), 32'd0);

        // sub Q - M = 0x05 - 0x0A
        do_op(2'b01, 8'h0A, 8'h05, 8'h00, 0, 0, hi, lo, lat, xf, sh, viol, tmo);
        check("sub_result", {16'h0, hi, lo}, 32'h0000FFFB);
        check("sub_latency", 32'(lat), 32'd4);

        // signed mul 7 * -3
        do_op(2'b10, 8'h07, 8'hFD, 8'h00, 0, 0, hi, lo, lat, xf, sh, viol, tmo);
        check("mul_result", {16'h0, hi, lo}, 32'h0000FFEB);
        check("mul_shifts", 32'(sh), 32'd8);
        check("mul_latency", 32'(lat), 32'd20);
        check("mul_strobes", 32'(viol), 32'd0);

        // div 100 / 7
        do_op(2'b11, 8'h07, 8'h64, 8'h00, 0, 0, hi, lo, lat, xf, sh, viol, tmo);
        check("div_result", {16'h0, hi, lo}, 32'h0000020E);
        check("div_xfers", 32'(xf), 32'd3);
        check("div_shifts", 32'(sh), 32'd8);
        check("div_busy_after", 32'(bus.busy), 32'h0);

        // stalls on input and output
        do_op(2'b10, 8'h07, 8'hFD, 8'h00, 3, 5, hi, lo, lat, xf, sh, viol, tmo);
        check("stall_mul_result", {16'h0, hi, lo}, 32'h0000FFEB);
        check("stall_mul_strobes", 32'(viol), 32'd0);
        check("stall_mul_latency", 32'(lat), 32'd23);
        do_op(2'b00, 8'h32, 8'h64, 8'h00, 3, 5, hi, lo, lat, xf, sh, viol, tmo);
        check("stall_add_result", {16'h0, hi, lo}, 32'h00000096);
        check("stall_add_strobes", 32'(viol), 32'd0);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.start = 1'b1; bus.op_in = 2'b10; bus.in_valid = 1'b1; in_byte = 8'h05;
        cyc = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!c4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("mul_sh_reached", 32'(c4 & c5), 32'h1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_reset_outputs", 32'(all_outs), 32'h0);
        @(negedge clk);
        check("mid_reset_hold", 32'(all_outs), 32'h0);
        rst = 1'b1;
        #1;
        check("after_reset_idle", 32'(all_outs), 32'h0);
        do_op(2'b00, 8'h01, 8'h01, 8'h00, 0, 0, hi, lo, lat, xf, sh, viol, tmo);
        check("post_reset_add", {16'h0, hi, lo}, 32'h00000002);
        check("post_reset_latency", 32'(lat), 32'd4);

        // randomized operations against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ropc = 2'($urandom_range(0, 3));
            rm   = 8'($urandom);
            rq   = 8'($urandom);
            ra   = 8'h00;
            if (ropc == 2'b10 && rm == 8'h80) rm = 8'h7F;
            if (ropc == 2'b11) begin
                rm = 8'($urandom_range(1, 127));
                ra = 8'($urandom_range(0, 32'(rm) - 1));
            end
            do_op(ropc, rm, rq, ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  hi, lo, lat, xf, sh, viol, tmo);
            check("rand_result", {16'h0, hi, lo}, {16'h0, ref_result(ropc, rm, rq, ra)});
            check("rand_strobes", 32'(viol) + 32'(tmo), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
